// File: rtl/calc_rpn_sys.sv
// calc_rpn_sys: RPN stack calculator with a 4-digit multiplexed hex display.
//   clk, reset   : single clock; synchronous active-high reset
//   load         : push in[W-1:0] onto the operand stack
//   calc         : execute opcode in[2:0]
//                  (ADD SUB AND OR XOR MUL DUP DROP)
//   ready        : command can be accepted (low while MUL iterates)
//   out / count  : top of stack (0 when empty) and number of valid entries
//   err          : the last accepted command faulted (overflow/underflow)
//   seg/an/dp    : active-low 7-seg segments a..g, digit enables, decimal point
module calc_rpn_sys #(
  parameter int W      = 8,
  parameter int DEPTH  = 4,
  parameter int CDBITS = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         calc,
  input  logic [W-1:0] in,
  output logic         ready,
  output logic [W-1:0] out,
  output logic [4:0]   count,
  output logic         err,
  output logic [0:6]   seg,
  output logic [3:0]   an,
  output logic         dp
);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ITW = $clog2(W);
  localparam logic [4:0]     DEPTH5  = 5'(DEPTH);
  localparam logic [ITW-1:0] IT_LAST = ITW'(W - 1);

  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;

  logic [DEPTH-1:0][W-1:0] stk;
  logic [4:0]        cnt_q;
  logic              err_q;
  logic [W-1:0]      mc_q, mp_q, acc_q;   // multiplicand, multiplier, partial sum
  logic [ITW-1:0]    it_q;
  logic [CDBITS-1:0] rc_q;

  logic [IW-1:0] tos_i, nos_i, push_i;
  logic [W-1:0]  tos, nos, alu_r, mul_step;
  logic [2:0]    op;
  logic          acc_load, acc_calc, start_mul, mul_done, two_ok;

  assign tos_i  = IW'(cnt_q - 5'd1);
  assign nos_i  = IW'(cnt_q - 5'd2);
  assign push_i = IW'(cnt_q);
  assign tos    = stk[tos_i];
  assign nos    = stk[nos_i];
  assign op     = in[2:0];
  assign two_ok = (cnt_q >= 5'd2);

  // control: load wins over calc; nothing is accepted while MUL iterates
  always_comb begin
    state_d   = state_q;
    ready     = (state_q == IDLE);
    acc_load  = ready & load;
    acc_calc  = ready & calc & ~load;
    start_mul = acc_calc && (op == 3'b101) && two_ok;
    mul_done  = (state_q == MUL) && (it_q == IT_LAST);
    if (start_mul) state_d = MUL;
    if (mul_done)  state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    alu_r = '0;
    case (op)
      3'b000:  alu_r = nos + tos;
      3'b001:  alu_r = nos - tos;
      3'b010:  alu_r = nos & tos;
      3'b011:  alu_r = nos | tos;
      3'b100:  alu_r = nos ^ tos;
      default: alu_r = '0;
    endcase
  end

  // one shift-add step per MUL cycle; the last step's sum is the product
  assign mul_step = acc_q + (mp_q[0] ? mc_q : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      stk   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      mc_q  <= '0;
      mp_q  <= '0;
      acc_q <= '0;
      it_q  <= '0;
      rc_q  <= '0;
    end else begin
      rc_q <= rc_q + 1'b1;
      if (acc_load) begin
        if (cnt_q == DEPTH5) err_q <= 1'b1;
        else begin
          stk[push_i] <= in;
          cnt_q       <= cnt_q + 5'd1;
          err_q       <= 1'b0;
        end
      end else if (acc_calc) begin
        case (op)
          3'b101: begin
            if (!two_ok) err_q <= 1'b1;
            else begin
              err_q <= 1'b0;
              mc_q  <= nos;
              mp_q  <= tos;
              acc_q <= '0;
              it_q  <= '0;
            end
          end
          3'b110: begin
            if (cnt_q == 5'd0 || cnt_q == DEPTH5) err_q <= 1'b1;
            else begin
              stk[push_i] <= tos;
              cnt_q       <= cnt_q + 5'd1;
              err_q       <= 1'b0;
            end
          end
          3'b111: begin
            if (cnt_q == 5'd0) err_q <= 1'b1;
            else begin
              cnt_q <= cnt_q - 5'd1;
              err_q <= 1'b0;
            end
          end
          default: begin
            if (!two_ok) err_q <= 1'b1;
            else begin
              stk[nos_i] <= alu_r;
              cnt_q      <= cnt_q - 5'd1;
              err_q      <= 1'b0;
            end
          end
        endcase
      end else if (state_q == MUL) begin
        acc_q <= mul_step;
        mc_q  <= mc_q << 1;
        mp_q  <= mp_q >> 1;
        it_q  <= it_q + 1'b1;
        // stack stays untouched until the product is ready
        if (mul_done) begin
          stk[nos_i] <= mul_step;
          cnt_q      <= cnt_q - 5'd1;
        end
      end
    end
  end

  assign out   = (cnt_q == 5'd0) ? '0 : tos;
  assign count = cnt_q;
  assign err   = err_q;

  // display: top two refresh bits pick the digit, nibble d of zero-extended out
  logic [1:0]  dig;
  logic [15:0] oz;
  logic [3:0]  nib;
  assign dig = rc_q[CDBITS-1 -: 2];

  always_comb begin
    oz        = '0;
    oz[W-1:0] = out;
    nib       = oz[{dig, 2'b00} +: 4];
  end

  always_comb begin
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  end

  assign an = ~(4'b0001 << dig);
  assign dp = ~((dig == 2'd0) & err_q);
endmodule

// File: tb/tb_calc_rpn_sys.sv
// Directed bench for calc_rpn_sys (W=8, DEPTH=4, short refresh counter).
module tb_calc_rpn_sys;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0, calc = 1'b0;
  logic [W-1:0] in = '0;
  logic         ready, err, dp;
  logic [W-1:0] out;
  logic [4:0]   count;
  logic [0:6]   seg;
  logic [3:0]   an;

  int n_chk = 0, n_fail = 0;

  calc_rpn_sys #(.W(W), .DEPTH(4), .CDBITS(4)) dut (
    .clk(clk), .reset(reset), .load(load), .calc(calc), .in(in),
    .ready(ready), .out(out), .count(count), .err(err),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // one clock with the given command, outputs sampled 1ns after the edge
  task automatic cyc(input logic l, input logic c, input logic [W-1:0] d);
    load = l; calc = c; in = d;
    @(posedge clk); #1;
    load = 1'b0; calc = 1'b0; in = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 0);
    reset = 1'b0;
  endtask

  // wait (bounded) until the given digit is enabled
  task automatic wait_an(input logic [3:0] want, input string tag);
    int k = 0;
    while (an !== want && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, an, want);
  endtask

  initial begin
    // reset state and display
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_out",   out,   0);
    chk("rst_err",   err,   0);
    chk("rst_ready", ready, 1);
    chk("rst_an",    an,    4'b1110);
    chk("rst_seg",   seg,   7'b0000001);
    chk("rst_dp",    dp,    1);

    // 5 + 3
    cyc(1, 0, 5);
    chk("ld5_out", out, 5);  chk("ld5_cnt", count, 1); chk("ld5_rdy", ready, 1);
    cyc(1, 0, 3);
    chk("ld3_out", out, 3);  chk("ld3_rdy", ready, 1);
    cyc(0, 1, 3'b000);
    chk("add_out", out, 8);  chk("add_cnt", count, 1);
    chk("add_err", err, 0);  chk("add_rdy", ready, 1);

    // SUB wrap, DUP, XOR, OR, AND
    do_reset();
    cyc(1, 0, 3); cyc(1, 0, 5); cyc(0, 1, 3'b001);
    chk("sub_out", out, 8'hFE); chk("sub_cnt", count, 1);
    cyc(0, 1, 3'b110);
    chk("dup_out", out, 8'hFE); chk("dup_cnt", count, 2);
    cyc(0, 1, 3'b100);
    chk("xor_out", out, 0); chk("xor_cnt", count, 1);
    cyc(1, 0, 8'hF0); cyc(0, 1, 3'b011);
    chk("or_out", out, 8'hF0);
    cyc(1, 0, 8'h3C); cyc(0, 1, 3'b010);
    chk("and_out", out, 8'h30); chk("and_cnt", count, 1);

    // 20 * 30, ready low for 8 cycles
    do_reset();
    cyc(1, 0, 20); cyc(1, 0, 30); cyc(0, 1, 3'b101);
    chk("mul_rdy0", ready, 0);
    chk("mul_hold_out", out, 30);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0);
      chk("mul_rdy_low", ready, 0);
      chk("mul_hold_cnt", count, 2);
    end
    cyc(0, 0, 0);
    chk("mul_rdy1", ready, 1);
    chk("mul_out", out, 8'h58);
    chk("mul_cnt", count, 1);

    // overflow then DROP
    do_reset();
    for (int v = 1; v <= 4; v++) cyc(1, 0, 8'(v));
    chk("fill_err", err, 0);
    cyc(1, 0, 5);
    chk("ovf_err", err, 1); chk("ovf_cnt", count, 4); chk("ovf_out", out, 4);
    cyc(0, 1, 3'b110);
    chk("dupovf_err", err, 1); chk("dupovf_cnt", count, 4);
    cyc(0, 1, 3'b111);
    chk("drop_err", err, 0); chk("drop_cnt", count, 3); chk("drop_out", out, 3);

    // underflow on empty stack, dp lit on digit 0
    do_reset();
    cyc(0, 1, 3'b001);
    chk("unf_err", err, 1); chk("unf_cnt", count, 0); chk("unf_out", out, 0);
    wait_an(4'b1110, "unf_an0");
    chk("unf_dp", dp, 0);
    wait_an(4'b1101, "unf_an1");
    chk("unf_dp1", dp, 1);

    // reset aborts MUL; commands while busy ignored
    do_reset();
    cyc(1, 0, 7); cyc(1, 0, 9); cyc(0, 1, 3'b101);
    cyc(1, 0, 8'h55);
    chk("busy_ld_cnt", count, 2); chk("busy_ld_out", out, 9);
    cyc(0, 1, 3'b111);
    chk("busy_calc_cnt", count, 2); chk("busy_err", err, 0); chk("busy_rdy", ready, 0);
    do_reset();
    chk("abort_cnt", count, 0); chk("abort_out", out, 0); chk("abort_rdy", ready, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    chk("abort_late_cnt", count, 0); chk("abort_late_out", out, 0);

    // load+calc together -> push only; display scan
    do_reset();
    cyc(1, 1, 8'hAB);
    chk("lc_cnt", count, 1); chk("lc_out", out, 8'hAB); chk("lc_err", err, 0);
    wait_an(4'b1110, "scan_an0"); chk("scan_seg0", seg, 7'b1100000);
    wait_an(4'b1101, "scan_an1"); chk("scan_seg1", seg, 7'b0001000);
    wait_an(4'b1011, "scan_an2"); chk("scan_seg2", seg, 7'b0000001);
    wait_an(4'b0111, "scan_an3"); chk("scan_seg3", seg, 7'b0000001);
    chk("scan_dp", dp, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_rpn_sys.md
CALC_RPN_SYS -- requirements
Module: calc_rpn_sys

Interface
REQ-001 The block SHALL have parameter W, default 8, legal 4..16: operand and result width.
REQ-002 The block SHALL have parameter DEPTH, default 4, legal 2..16: operand stack entries.
REQ-003 The block SHALL have parameter CDBITS, default 18, legal >= 4: display refresh counter width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset:
  clk  in  1  clock; all state changes on the rising edge.
  reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have these remaining ports:
  load  in  1  push in[W-1:0] onto the stack.
  calc  in  1  execute the opcode in in[2:0].
  in  in  W  operand data or opcode.
  ready  out  1  high when a command can be accepted.
  out  out  W  top of stack (TOS); 0 when the stack is empty.
  count  out  5  number of valid stack entries.
  err  out  1  the last command issued faulted.
  seg  out  [0:6]  segments a..g, active-low.
  an  out  4  digit enables, active-low, one-hot.
  dp  out  1  decimal point, active-low.

Function
REQ-006 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 DUP, 111 DROP.
REQ-007 Binary ops SHALL pop NOS and TOS, then push (NOS op TOS); SUB = NOS-TOS; results SHALL be modulo 2^W with no carry or overflow flag.
REQ-008 A command SHALL be accepted only on an edge where ready=1; load or calc while ready=0 SHALL be ignored without changing err.
REQ-009 If load and calc are both high on an accepted edge, the block SHALL execute load and ignore calc.
REQ-010 An accepted load SHALL update out and count at that edge; ready SHALL stay 1.
REQ-011 ADD, SUB, AND, OR, XOR, DUP and DROP SHALL complete at the accepting edge; ready SHALL stay 1.
REQ-012 MUL SHALL be iterative shift-add: the FSM goes IDLE->MUL at acceptance; ready=0 for the next W cycles; the product and ready=1 SHALL be visible after edge W+1, counting the accepting edge as edge 1.
REQ-013 While MUL is active, out and count SHALL hold their pre-command values.
REQ-014 Overflow: a load or DUP with count=DEPTH SHALL set err=1 and leave the stack unchanged.
REQ-015 Underflow: a binary op with count<2, or DUP or DROP with count=0, SHALL set err=1 and leave the stack unchanged.
REQ-016 Any accepted non-faulting command SHALL clear err at its accepting edge.
REQ-017 A CDBITS-bit free-running refresh counter SHALL select digit d = counter[CDBITS-1:CDBITS-2]; an[d]=0 and all other an bits =1.
REQ-018 Digit d SHALL display hex nibble d of out, zero-extended to 16 bits, using standard 0-F patterns (0 -> seg=0000001).
REQ-019 dp SHALL be 0 only when d=0 and err=1; otherwise 1.

Reset
REQ-020 When reset=1 at an edge, the block SHALL set: stack empty, count=0, out=0, err=0, ready=1, FSM=IDLE, refresh counter=0.
REQ-021 After reset the display SHALL show an=1110, seg=0000001, dp=1.
REQ-022 Reset SHALL take priority over load and calc, and SHALL abort an in-progress MUL with no result pushed.

Verification
REQ-023 Reset, load 5, load 3, calc ADD -> out=8, count=1, err=0, ready stays 1 throughout.
REQ-024 W=8: load 20, load 30, calc MUL -> ready=0 for 8 cycles, then out=0x58 (600 mod 256), count=1.
REQ-025 DEPTH=4: five loads -> 5th sets err=1, count=4, out = 4th value; a following DROP -> err=0, count=3.
REQ-026 Empty stack: calc SUB -> err=1, count=0, out=0, dp=0 while an=1110.
REQ-027 Load 7, load 9, calc MUL, reset asserted in MUL cycle 3 -> count=0, out=0, ready=1 next cycle; load and calc issued while ready=0 are ignored.
REQ-028 Load 0xAB with load and calc (ADD) both high -> push only, count=1; display scans digits 0..3 showing B, A, 0, 0.
